// File: rtl/apb_arbiter_pkg.sv
// apb_arbiter_pkg: shared types and constants for the APB segment arbiter.
// Holds the FSM state encoding, the port-count ceiling and the abort read data.
// Imported by apb_arbiter and apb_arbiter_rr_picker.
package apb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DSETUP  = 2'd1,
    DACCESS = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam int          ARB_MAX_PORTS    = 8;
  localparam logic [31:0] ARB_TIMEOUT_DATA = 32'h0;

endpackage

// File: rtl/apb_arbiter_rr_picker.sv
// apb_arbiter_rr_picker: round-robin choice among requesting ports.
// Latency: purely combinational; the search starts at last_grant+1 mod NUM_PORTS.
// Backpressure: none; vld_o is low when no port requests.
module apb_arbiter_rr_picker #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     last_grant_i,
  output logic                 vld_o,
  output logic [IDX_W-1:0]     idx_o
);

  // Walk offsets from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    int cand;
    cand  = 0;
    vld_o = 1'b0;
    idx_o = '0;
    for (int off = NUM_PORTS; off >= 1; off--) begin
      cand = int'(last_grant_i) + off;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      if (req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// apb_arbiter: shares one downstream APB segment between NUM_PORTS upstream requesters.
// Latency: upstream SETUP at cycle 0 -> downstream SETUP cycle 1, upstream pready cycle 3 (+1 per wait).
// Backpressure: non-granted upstream ports see pready=0 until served; APB_ARBITER_TIMEOUT_EN adds a DACCESS watchdog.
// Requests are keyed on upstream psel only; all upstream fields are latched once at the grant.
module apb_arbiter
  import apb_arbiter_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int IDX_W          = $clog2(NUM_PORTS)
) (
  input  logic                                  pclk,
  input  logic                                  rst,
  // upstream (completer side, one lane per requester)
  input  logic [NUM_PORTS-1:0]                  us_psel_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  us_paddr_i,
  input  logic [NUM_PORTS-1:0]                  us_pwrite_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  us_pwdata_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] us_pstrb_i,
  input  logic [NUM_PORTS-1:0][2:0]             us_pprot_i,
  output logic [NUM_PORTS-1:0]                  us_pready_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  us_prdata_o,
  output logic [NUM_PORTS-1:0]                  us_pslverr_o,
  output logic [NUM_PORTS-1:0]                  us_pruser_o,
  output logic [NUM_PORTS-1:0]                  us_pbuser_o,
  // downstream (requester side, shared segment)
  output logic                                  ds_psel_o,
  output logic                                  ds_penable_o,
  output logic [ADDR_WIDTH-1:0]                 ds_paddr_o,
  output logic                                  ds_pwrite_o,
  output logic [DATA_WIDTH-1:0]                 ds_pwdata_o,
  output logic [DATA_WIDTH/8-1:0]               ds_pstrb_o,
  output logic [2:0]                            ds_pprot_o,
  output logic                                  ds_pauser_o,
  output logic                                  ds_pwuser_o,
  input  logic [DATA_WIDTH-1:0]                 ds_prdata_i,
  input  logic                                  ds_pready_i,
  input  logic                                  ds_pslverr_i,
  // status
  output logic [IDX_W-1:0]                      grant_id,
  output logic                                  busy
);

  localparam int STRB_W = DATA_WIDTH / 8;

  if (NUM_PORTS < 2 || NUM_PORTS > ARB_MAX_PORTS) begin : g_bad_ports
    $error("apb_arbiter: NUM_PORTS out of range 2..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  arb_state_t                            state_q;
  logic [IDX_W-1:0]                      grant_q;
  logic [IDX_W-1:0]                      last_q;
  logic                                  busy_q;
  logic                                  ds_psel_q;
  logic                                  ds_penable_q;
  logic                                  ds_pwrite_q;
  logic [ADDR_WIDTH-1:0]                 ds_paddr_q;
  logic [DATA_WIDTH-1:0]                 ds_pwdata_q;
  logic [STRB_W-1:0]                     ds_pstrb_q;
  logic [2:0]                            ds_pprot_q;
  logic [NUM_PORTS-1:0]                  us_pready_q;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  us_prdata_q;
  logic [NUM_PORTS-1:0]                  us_pslverr_q;

  logic                                  pick_vld;
  logic [IDX_W-1:0]                      pick_idx;

`ifdef APB_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q;
`endif

  apb_arbiter_rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req_i        (us_psel_i),
    .last_grant_i (last_q),
    .vld_o        (pick_vld),
    .idx_o        (pick_idx)
  );

  // Transaction FSM: grant in IDLE, replay downstream, return the registered response.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= IDX_W'(NUM_PORTS - 1);
      busy_q       <= 1'b0;
      ds_psel_q    <= 1'b0;
      ds_penable_q <= 1'b0;
      ds_pwrite_q  <= 1'b0;
      ds_paddr_q   <= '0;
      ds_pwdata_q  <= '0;
      ds_pstrb_q   <= '0;
      ds_pprot_q   <= '0;
      us_pready_q  <= '0;
      us_prdata_q  <= '0;
      us_pslverr_q <= '0;
`ifdef APB_ARBITER_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q      <= DSETUP;
            grant_q      <= pick_idx;
            last_q       <= pick_idx;
            busy_q       <= 1'b1;
            ds_psel_q    <= 1'b1;
            ds_penable_q <= 1'b0;
            ds_paddr_q   <= us_paddr_i[pick_idx];
            ds_pwrite_q  <= us_pwrite_i[pick_idx];
            ds_pwdata_q  <= us_pwdata_i[pick_idx];
            ds_pstrb_q   <= us_pstrb_i[pick_idx];
            ds_pprot_q   <= us_pprot_i[pick_idx];
          end
        end
        DSETUP: begin
          state_q      <= DACCESS;
          ds_penable_q <= 1'b1;
`ifdef APB_ARBITER_TIMEOUT_EN
          to_cnt_q     <= '0;
`endif
        end
        DACCESS: begin
          // A pready coinciding with the watchdog limit is a normal completion.
          if (ds_pready_i) begin
            state_q               <= RESP;
            ds_psel_q             <= 1'b0;
            ds_penable_q          <= 1'b0;
            us_pready_q[grant_q]  <= 1'b1;
            us_prdata_q[grant_q]  <= ds_prdata_i;
            us_pslverr_q[grant_q] <= ds_pslverr_i;
          end
`ifdef APB_ARBITER_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            state_q               <= RESP;
            ds_psel_q             <= 1'b0;
            ds_penable_q          <= 1'b0;
            us_pready_q[grant_q]  <= 1'b1;
            us_prdata_q[grant_q]  <= DATA_WIDTH'(ARB_TIMEOUT_DATA);
            us_pslverr_q[grant_q] <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
`endif
        end
        RESP: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          us_pready_q  <= '0;
          us_prdata_q  <= '0;
          us_pslverr_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ds_psel_o    = ds_psel_q;
  assign ds_penable_o = ds_penable_q;
  assign ds_paddr_o   = ds_paddr_q;
  assign ds_pwrite_o  = ds_pwrite_q;
  assign ds_pwdata_o  = ds_pwdata_q;
  assign ds_pstrb_o   = ds_pstrb_q;
  assign ds_pprot_o   = ds_pprot_q;
  assign ds_pauser_o  = 1'b0;
  assign ds_pwuser_o  = 1'b0;
  assign us_pready_o  = us_pready_q;
  assign us_prdata_o  = us_prdata_q;
  assign us_pslverr_o = us_pslverr_q;
  assign us_pruser_o  = '0;
  assign us_pbuser_o  = '0;
  assign grant_id     = grant_q;
  assign busy         = busy_q;

endmodule

// File: doc/apb_arbiter.md
# apb_arbiter

Shares one downstream APB segment between NUM_PORTS upstream APB requesters, e.g. the FMC bridge and a future on-chip DMA or debug master. Accepts one upstream transaction at a time, replays it downstream and registers the response back to the granted requester. Grants are round-robin. An optional watchdog terminates downstream accesses that never complete.

## Interface
Parameters:
- NUM_PORTS, 2: number of upstream requesters, legal range 2..8.
- TIMEOUT_CYCLES, 1023: maximum number of downstream ACCESS cycles before abort. Used only with the watchdog. Legal range 1..65535.

Ports:
- pclk  input  1  APB clock; all logic is in this single domain.
- rst  input  1  asynchronous, active-high reset.
- upstream[NUM_PORTS-1:0]  APB completer modport  interface array  requester side. DATA_WIDTH and ADDR_WIDTH match downstream.
- downstream  APB requester modport  interface  shared segment.
- grant_id  output  $clog2(NUM_PORTS)  index of the port currently being served. Valid while busy is 1.
- busy  output  1  high from the cycle a grant is taken until the cycle after RESP.

## Operation
- FSM states: IDLE, DSETUP, DACCESS, RESP.
- IDLE: a port is a candidate when psel=1 on that port.
  - If no port is a candidate, stay in IDLE.
  - If one or more ports are candidates, choose one round-robin, starting the search at last_grant+1 mod NUM_PORTS.
  - Latch paddr, pwrite, pwdata, pstrb and pprot from the chosen port, set grant_id and last_grant, then go to DSETUP.
- DSETUP: drive downstream psel=1, penable=0 with the latched fields. Go to DACCESS.
- DACCESS: drive downstream psel=1, penable=1.
  - On downstream pready=1, capture prdata and pslverr, then go to RESP.
- RESP: drive upstream[grant_id] pready=1 with the captured prdata and pslverr for exactly one cycle. Go to IDLE.
- Upstream ports other than the granted one hold pready=0, which stretches their ACCESS phase. Their prdata is 0.
- Upstream pruser and pbuser are 0. Downstream user fields are 0.
- Upstream field changes after the IDLE latch are ignored.
- A port that drops psel before its grant is never served. No state is kept for it.
- Reset values: downstream psel, penable, pwrite = 0; paddr, pwdata, pstrb, pprot = 0; all upstream pready, prdata, pslverr = 0; busy = 0; grant_id = 0; last_grant = NUM_PORTS-1, so port 0 wins the first contention; FSM = IDLE.
- Reset mid-transaction drops the downstream transaction immediately, with no completion. The upstream requester never sees pready.

## Timing
- All outputs are registered.
- Minimum latency, with upstream SETUP at cycle 0 and downstream zero wait states:
  - cycle 1: downstream SETUP
  - cycle 2: downstream ACCESS with pready
  - cycle 3: upstream pready
  - cycle 4: IDLE, so the next grant can be latched; that grant's downstream SETUP is at cycle 5.
- Each downstream wait state adds one cycle.
- Back-to-back requests from the same port are not starved: round-robin guarantees service within NUM_PORTS transactions.
- Simultaneous requests in IDLE: exactly one grant per IDLE cycle. Other requesters wait.

## Configuration
- APB_ARBITER_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to DACCESS and increments each DACCESS cycle.
  - When the counter reaches TIMEOUT_CYCLES with downstream pready still 0, drive downstream psel/penable to 0 and go to RESP with pslverr=1 and prdata=32'h0.
  - If pready arrives in the same cycle the limit is hit, pready wins: normal completion.
- Not defined: no counter exists, and DACCESS waits indefinitely.

## Structure
- Package apb_arbiter_pkg:
  - arb_state_t enum {IDLE, DSETUP, DACCESS, RESP}
  - ARB_MAX_PORTS = 8
  - ARB_TIMEOUT_DATA = 32'h0
- Sub-module apb_arbiter_rr_picker:
  - Combinational round-robin.
  - Inputs: request vector, last_grant.
  - Outputs: valid, index.

## Test plan
- Single port 0 write to 0x0010 of 0xcafe_babe, downstream zero-wait -> downstream SETUP at cycle 1, upstream pready at cycle 3, pslverr=0, busy low at cycle 4.
- Ports 0 and 1 request simultaneously after reset -> port 0 is served first; port 1's downstream SETUP is at cycle 5. A second contention grants port 1 first.
- Read with 3 downstream wait states returning 0x1234_5678 -> upstream pready at cycle 6 with prdata=0x1234_5678. The non-granted port sees pready=0 throughout.
- Downstream pslverr=1 on a read -> the granted port sees pslverr=1 in the RESP cycle only.
- With APB_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=4, downstream never ready -> abort after 4 ACCESS cycles, upstream pslverr=1, prdata=0. Without the macro, the transaction is still pending after 100 cycles.
- rst asserted during DACCESS -> next edge: downstream psel=0, busy=0, FSM=IDLE. After release, port 0 wins the first contention.
